panda_muldiv: RTL and testbench

- Iterative RV32M multiply/divide unit for the Panda core, parametrised in datapath width.
- Sits beside the single-cycle ALU in the execute stage. The decoder steers OPCODE_OP instructions with funct7=0000001 to it.
- Operates on a valid/ready handshake and stalls the pipeline while busy.
- One result at a time; radix-2 shift-add multiply and restoring divide.

---
 rtl/panda_pkg.sv | 30 +++
 rtl/panda_muldiv_special.sv | 68 ++++++
 rtl/panda_muldiv.sv | 144 ++++++++++++++
 tb/tb_panda_muldiv.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panda_pkg.sv
// Shared Panda core definitions: multiply/divide operator encoding and FSM states.
package panda_pkg;

    // funct7 value that steers OPCODE_OP instructions to the multiply/divide unit
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // RV32M operators, encoded as funct3
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_operator_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_DONE
    } md_state_e;

    // Divide/remainder operators all have funct3[2] set
    function automatic logic md_is_div(input md_operator_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/panda_muldiv_special.sv
// Special-case detection for multiply/divide: operands whose result is known
// without iterating. Shared with the decoder's fast-path checks.
module panda_muldiv_special
    import panda_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  md_operator_e    op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            special_o,
    output logic [XLEN-1:0] result_o
);

    logic a_zero;
    logic b_zero;
    logic ovf;

    assign a_zero = (a_i == '0);
    assign b_zero = (b_i == '0);
    assign ovf    = (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);

    // Select the short-circuit result for zero operands and signed overflow
    always_comb begin
        special_o = 1'b0;
        result_o  = '0;
        case (op_i)
            MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU: begin
                if (a_zero || b_zero) begin
                    special_o = 1'b1;
                end
            end
            MD_DIV: begin
                if (b_zero) begin
                    special_o = 1'b1;
                    result_o  = '1;
                end else if (ovf) begin
                    special_o = 1'b1;
                    result_o  = a_i;
                end
            end
            MD_DIVU: begin
                if (b_zero) begin
                    special_o = 1'b1;
                    result_o  = '1;
                end
            end
            MD_REM: begin
                if (b_zero) begin
                    special_o = 1'b1;
                    result_o  = a_i;
                end else if (ovf) begin
                    special_o = 1'b1;
                end
            end
            MD_REMU: begin
                if (b_zero) begin
                    special_o = 1'b1;
                    result_o  = a_i;
                end
            end
            default: begin
                special_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/panda_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, valid/ready on both sides.
module panda_muldiv
    import panda_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  md_operator_e    op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    md_state_e         state;
    logic [CNT_W-1:0]  cnt;
    md_operator_e      op_q;
    logic [2*XLEN-1:0] acc;    // mul: product/multiplier, div: remainder/quotient
    logic [XLEN-1:0]   opb;    // multiplicand or divisor magnitude
    logic              neg_q;  // negate the selected result at the end

    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            spec_hit;
    logic [XLEN-1:0] spec_res;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_nxt, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

    assign ready_o = (state == MD_IDLE);
    assign busy_o  = (state != MD_IDLE);

    panda_muldiv_special #(
        .XLEN(XLEN)
    ) u_special (
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .special_o(spec_hit),
        .result_o (spec_res)
    );

    // Operand magnitudes and signs for the request being offered
    always_comb begin
        a_sgn = (op_i == MD_MULH) || (op_i == MD_MULHSU) || (op_i == MD_DIV) || (op_i == MD_REM);
        b_sgn = (op_i == MD_MULH) || (op_i == MD_DIV) || (op_i == MD_REM);
        a_neg = a_sgn && a_i[XLEN-1];
        b_neg = b_sgn && b_i[XLEN-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
    end

    // One shift-add or restoring-subtract step, plus the sign-corrected result
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opb : '0)};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (md_is_div(op_q)) begin
            if (!div_diff[XLEN]) begin
                acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        end
        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        quo_fix  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem_fix  = neg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        case (op_q)
            MD_MUL:                         calc_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:   calc_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:                calc_res = quo_fix;
            default:                        calc_res = rem_fix;
        endcase
    end

    // Control FSM with registered result and valid
    // valid_o rises one cycle after DONE is entered, giving XLEN+1 cycles for
    // iterated ops and 1 cycle for special cases; ready_i counts only once valid_o is up.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            op_q     <= MD_MUL;
            acc      <= '0;
            opb      <= '0;
            neg_q    <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else if (kill_i) begin
            state   <= MD_IDLE;
            valid_o <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (valid_i) begin
                        op_q  <= op_i;
                        opb   <= b_mag;
                        acc   <= {{XLEN{1'b0}}, a_mag};
                        cnt   <= CNT_W'(XLEN - 1);
                        neg_q <= (md_is_div(op_i) && op_i[1]) ? a_neg : (a_neg ^ b_neg);
                        if (spec_hit) begin
                            result_o <= spec_res;
                            state    <= MD_DONE;
                        end else begin
                            state <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result_o <= calc_res;
                        state    <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (!valid_o) begin
                        valid_o <= 1'b1;
                    end else if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= MD_IDLE;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_panda_muldiv.sv
// Self-checking bench for panda_muldiv against a plain-arithmetic RV32M model.
module tb_panda_muldiv;
    import panda_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    md_operator_e op_i = MD_MUL;
    logic [31:0]  a_i = '0;
    logic [31:0]  b_i = '0;
    logic         kill_i = 1'b0;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [31:0]  result_o;
    logic         busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    panda_muldiv #(
        .XLEN(XLEN)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .kill_i  (kill_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .result_o(result_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // RV32M reference using 64-bit integer arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = 64'(ua / ub); return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = 64'(ua % ub); return p[31:0];
            end
        endcase
    endfunction

    // Expected cycles from accept edge to valid_o
    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic spec;
        if (op < 3'd4) spec = (a == 0) || (b == 0);
        else spec = (b == 0) || ((op == 3'd4 || op == 3'd6) && a == MIN_INT && b == 32'hFFFF_FFFF);
        return spec ? 1 : XLEN + 1;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return MIN_INT;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    // Offer one request, wait for the result; ready_i held at hold_ready meanwhile
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic hold_ready, output logic [31:0] res, output int lat);
        int w = 0;
        @(negedge clk_i);
        op_i = md_operator_e'(op); a_i = a; b_i = b; valid_i = 1'b1; ready_i = hold_ready;
        while (!ready_o && w < 100) begin
            @(negedge clk_i);
            w++;
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        op_i = md_operator_e'($urandom_range(0, 7)); a_i = $urandom; b_i = $urandom;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk_i);
            #1;
            lat++;
            if (valid_o) break;
        end
        res = result_o;
    endtask

    task automatic consume();
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b1;
        #1;
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", ready_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        n_checks++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h want=0", result_o); end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[$];
        logic [31:0] res;
        int lat;
        v.push_back('{3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        v.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        v.push_back('{3'd1, MIN_INT,      MIN_INT,      32'h4000_0000, 33});
        v.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
        v.push_back('{3'd4, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA, 33});
        v.push_back('{3'd6, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, 33});
        v.push_back('{3'd5, 32'd100,      32'd7,        32'd14,        33});
        v.push_back('{3'd7, 32'd100,      32'd7,        32'd2,         33});
        v.push_back('{3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 1});
        v.push_back('{3'd6, 32'd5,        32'd0,        32'd5,         1});
        v.push_back('{3'd4, MIN_INT,      32'hFFFF_FFFF, MIN_INT,      1});
        v.push_back('{3'd6, MIN_INT,      32'hFFFF_FFFF, 32'd0,        1});
        v.push_back('{3'd1, 32'd0,        32'h1234_5678, 32'd0,        1});
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, 1'b0, res, lat);
            n_checks++; if (res !== v[i].exp) begin n_fail++; $display("FAIL directed_result[%0d] got=%h want=%h", i, res, v[i].exp); end
            n_checks++; if (lat != v[i].lat) begin n_fail++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, v[i].lat); end
            n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL directed_ready_in_done[%0d] got=%b want=0", i, ready_o); end
            consume();
            n_checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL directed_handshake[%0d] valid=%b ready=%b want 0/1", i, valid_o, ready_o); end
        end
    endtask

    task automatic test_random();
        logic [31:0] res, a, b;
        logic [2:0] op;
        int lat;
        for (int unsigned i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a = rnd_operand();
            b = rnd_operand();
            run_op(op, a, b, 1'b0, res, lat);
            n_checks++; if (res !== ref_md(op, a, b)) begin n_fail++; $display("FAIL random_result op=%0d a=%h b=%h got=%h want=%h", op, a, b, res, ref_md(op, a, b)); end
            n_checks++; if (lat != ref_lat(op, a, b)) begin n_fail++; $display("FAIL random_latency op=%0d a=%h b=%h got=%0d want=%0d", op, a, b, lat, ref_lat(op, a, b)); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res, a, b, exp;
        int lat;
        int bad = 0;
        a = $urandom; b = $urandom | 32'h1;
        exp = ref_md(3'd1, a, b);
        run_op(3'd1, a, b, 1'b0, res, lat);
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL bp_result got=%h want=%h", res, exp); end
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clk_i);
            valid_i = (i < 5); op_i = MD_DIVU; a_i = $urandom; b_i = 32'd3;
            @(posedge clk_i);
            #1;
            if (valid_o !== 1'b1 || result_o !== exp || ready_o !== 1'b0) bad++;
        end
        valid_i = 1'b0;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold unstable_cycles got=%0d want=0", bad); end
        consume();
        n_checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_release busy=%b valid=%b want 0/0", busy_o, valid_o); end
    endtask

    task automatic test_kill();
        logic [31:0] res;
        int lat;
        int seen = 0;
        @(negedge clk_i);
        op_i = MD_MULHU; a_i = 32'hDEAD_BEEF; b_i = 32'h1234_5679; valid_i = 1'b1;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL kill_calc busy=%b ready=%b want 0/1", busy_o, ready_o); end
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL kill_no_valid got=%0d want=0", seen); end
        run_op(3'd5, 32'd9, 32'd2, 1'b0, res, lat);
        n_checks++; if (res !== 32'd4) begin n_fail++; $display("FAIL kill_next_divu got=%h want=4", res); end
        consume();
        // kill beats valid_i in IDLE
        @(negedge clk_i);
        op_i = MD_DIVU; a_i = 32'd50; b_i = 32'd5; valid_i = 1'b1; kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0; kill_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL kill_idle_accept busy got=%b want=0", busy_o); end
        // kill beats ready_i in DONE
        run_op(3'd7, 32'd50, 32'd0, 1'b0, res, lat);
        @(negedge clk_i);
        kill_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0; ready_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL kill_done valid=%b busy=%b want 0/0", valid_o, busy_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        op_i = MD_DIV; a_i = 32'h7654_3210; b_i = 32'd13; valid_i = 1'b1;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        n_checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid ready=%b valid=%b busy=%b want 1/0/0", ready_o, valid_o, busy_o); end
        n_checks++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset_mid_result got=%h want=0", result_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, a, b;
        logic [2:0] op;
        int lat;
        for (int unsigned i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 7));
            a = rnd_operand();
            b = rnd_operand();
            run_op(op, a, b, 1'b1, res, lat);
            n_checks++; if (res !== ref_md(op, a, b) || lat != ref_lat(op, a, b)) begin
                n_fail++; $display("FAIL b2b op=%0d a=%h b=%h got=%h/%0d want=%h/%0d", op, a, b, res, lat, ref_md(op, a, b), ref_lat(op, a, b));
            end
        end
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_final valid=%b ready=%b want 0/1", valid_o, ready_o); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
